// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : score_pkg                                               |
// | Description : Shared types, constants and helpers for the BCD score   |
// |               up-counter (digit type, state encoding, addend clamp).  |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } score_state_t;

  // Non-BCD codes 10..15 on the add port count as the largest legal digit.
  function automatic bcd_digit_t clamp_bcd(input logic [3:0] value);
    return (value > BCD_MAX) ? BCD_MAX : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_digit_adder                                         |
// | Description : Combinational single-digit BCD adder.                   |
// |               o_sum = (i_digit + i_addend + i_carry) mod 10,          |
// |               o_carry = sum > 9.                                      |
// | Ports       : i_digit   [3:0] current BCD digit                       |
// |               i_addend  [3:0] BCD addend (0..9)                       |
// |               i_carry         carry in                                |
// |               o_sum     [3:0] resulting BCD digit                     |
// |               o_carry         carry out                               |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module bcd_digit_adder
  import score_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [3:0] i_addend,
  input  logic       i_carry,
  output logic [3:0] o_sum,
  output logic       o_carry
);

  // Widest case is 9 + 9 + 1 = 19, which fits in 5 bits.
  logic [4:0] w_raw;
  logic [4:0] w_wrapped;

  assign w_raw     = {1'b0, i_digit} + {1'b0, i_addend} + {4'd0, i_carry};
  assign w_wrapped = w_raw - 5'd10;
  assign o_carry   = (w_raw > {1'b0, BCD_MAX});
  assign o_sum     = o_carry ? w_wrapped[3:0] : w_raw[3:0];

endmodule
`default_nettype wire

// File: rtl/score_up_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : score_up_counter                                        |
// | Description : Multi-digit BCD score accumulator. Accepts 0..9 point   |
// |               add requests via valid/ready and ripples the carry one  |
// |               digit per clock using a single shared digit adder.      |
// | Ports       : clk, reset (sync, active-high), clear (sync score clr)  |
// |               add_valid/add_value[3:0]/add_ready : add handshake      |
// |               digits[4*NUM_DIGITS-1:0] : BCD score, ones in [3:0]     |
// |               busy : ripple in progress, done : add complete pulse    |
// |               tc : all digits 9 (comb), ovf : overflow pulse          |
// | Config      : SCORE_SATURATE_EN - saturate at all-9s on overflow      |
// |               instead of wrapping.                                    |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module score_up_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 3
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    add_valid,
  input  logic [3:0]              add_value,
  output logic                    add_ready,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic                    tc,
  output logic                    ovf
);

  localparam int                 IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  score_state_t            r_state;
  logic [4*NUM_DIGITS-1:0] r_digits;
  bcd_digit_t              r_addend;
  logic                    r_carry;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_done;
  logic                    r_ovf;

  bcd_digit_t              w_cur_digit;
  bcd_digit_t              w_sum;
  logic                    w_carry_out;
  logic [NUM_DIGITS-1:0]   w_digit_is_max;

  // Only the digit currently addressed by the ripple index is fed to the adder.
  assign w_cur_digit = r_digits[r_idx*4 +: 4];

  bcd_digit_adder u_adder (
    .i_digit  (w_cur_digit),
    .i_addend (r_addend),
    .i_carry  (r_carry),
    .o_sum    (w_sum),
    .o_carry  (w_carry_out)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_addend <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (add_valid) begin
            r_addend <= clamp_bcd(add_value);
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_state  <= ADD;
          end
        end
        ADD: begin
          r_digits[r_idx*4 +: 4] <= w_sum;
          // Addend only applies to the ones digit; higher digits see carry only.
          r_addend <= '0;
          r_carry  <= w_carry_out;
          if (!w_carry_out) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_idx == LAST_IDX) begin
`ifdef SCORE_SATURATE_EN
            // Overrides the per-digit write above.
            r_digits <= {NUM_DIGITS{BCD_MAX}};
`endif
            r_carry <= 1'b0;
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_tc
      assign w_digit_is_max[g] = (r_digits[g*4 +: 4] == BCD_MAX);
    end
  endgenerate

  assign tc        = &w_digit_is_max;
  assign digits    = r_digits;
  assign add_ready = (r_state == IDLE);
  assign busy      = (r_state == ADD);
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_score_up_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_score_up_counter                                     |
// | Description : Directed self-checking bench for score_up_counter       |
// |               (NUM_DIGITS = 3). Honors SCORE_SATURATE_EN.             |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_score_up_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        add_valid;
  logic [3:0]  add_value;
  logic        add_ready;
  logic [11:0] digits;
  logic        busy;
  logic        done;
  logic        tc;
  logic        ovf;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  score_up_counter #(.NUM_DIGITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .add_valid (add_valid),
    .add_value (add_value),
    .add_ready (add_ready),
    .digits    (digits),
    .busy      (busy),
    .done      (done),
    .tc        (tc),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Issue one request (DUT must be idle) and wait for done.
  // lat = cycles from accept edge to the cycle done is visible.
  task automatic run_add(input logic [3:0] v, output int lat, output logic ready_seen);
    logic seen;
    seen       = 1'b0;
    ready_seen = 1'b0;
    lat        = 0;
    add_valid  = 1'b1;
    add_value  = v;
    tick();
    add_valid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (add_ready) ready_seen = 1'b1;
      tick();
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // From zero, reach target using adds of at most 9.
  task automatic build(input int target);
    int   s;
    int   lat;
    logic rs;
    s = 0;
    while (s < target) begin
      int v;
      v = (target - s > 9) ? 9 : target - s;
      run_add(4'(v), lat, rs);
      s += v;
    end
    check("build_value", {20'd0, digits}, {20'd0, to_bcd(target)});
  endtask

  initial begin
    int          lat;
    logic        rs;
    int          k;
    logic [11:0] exp_seq [3];

    reset     = 1'b1;
    clear     = 1'b0;
    add_valid = 1'b0;
    add_value = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_digits", {20'd0, digits}, 32'd0);
    check("rst_ready",  {31'd0, add_ready}, 32'd1);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_ovf",    {31'd0, ovf}, 32'd0);
    check("rst_tc",     {31'd0, tc}, 32'd0);

    // Add 7 from zero: one ADD cycle, busy during it
    add_valid = 1'b1;
    add_value = 4'd7;
    tick();
    add_valid = 1'b0;
    check("add7_busy",   {31'd0, busy}, 32'd1);
    check("add7_ready0", {31'd0, add_ready}, 32'd0);
    check("add7_nodone", {31'd0, done}, 32'd0);
    tick();
    check("add7_done",   {31'd0, done}, 32'd1);
    check("add7_digits", {20'd0, digits}, 32'h007);
    check("add7_ready1", {31'd0, add_ready}, 32'd1);
    check("add7_busy0",  {31'd0, busy}, 32'd0);
    check("add7_tc",     {31'd0, tc}, 32'd0);
    tick();
    check("add7_done_1cyc", {31'd0, done}, 32'd0);

    // 095 + 8 -> 103 after 3 ripple cycles
    do_clear();
    check("clr_digits", {20'd0, digits}, 32'd0);
    build(95);
    run_add(4'd8, lat, rs);
    check("r103_latency", lat, 32'd3);
    check("r103_ready_low", {31'd0, rs}, 32'd0);
    check("r103_digits", {20'd0, digits}, 32'h103);
    check("r103_ovf", {31'd0, ovf}, 32'd0);

    // 998 + 5 -> overflow
    do_clear();
    build(998);
    check("tc_998", {31'd0, tc}, 32'd0);
    run_add(4'd5, lat, rs);
    check("ovf_latency", lat, 32'd3);
    check("ovf_pulse", {31'd0, ovf}, 32'd1);
`ifdef SCORE_SATURATE_EN
    check("ovf_digits", {20'd0, digits}, 32'h999);
    check("ovf_tc", {31'd0, tc}, 32'd1);
`else
    check("ovf_digits", {20'd0, digits}, 32'h003);
    check("ovf_tc", {31'd0, tc}, 32'd0);
`endif
    tick();
    check("ovf_1cyc", {31'd0, ovf}, 32'd0);
    check("ovf_done_1cyc", {31'd0, done}, 32'd0);

    // 999 reached exactly: tc high
    do_clear();
    build(999);
    check("tc_999", {31'd0, tc}, 32'd1);

    // Clamp of non-BCD addend
    do_clear();
    run_add(4'hC, lat, rs);
    check("clamp_digits", {20'd0, digits}, 32'h009);
    check("clamp_latency", lat, 32'd1);

    // Clear during ripple of 099 + 1
    do_clear();
    build(99);
    add_valid = 1'b1;
    add_value = 4'd1;
    tick();
    add_valid = 1'b0;
    tick();
    check("abort_midripple_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_digits", {20'd0, digits}, 32'd0);
    check("abort_ready", {31'd0, add_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    tick();
    check("abort_done_later", {31'd0, done}, 32'd0);
    check("abort_digits_later", {20'd0, digits}, 32'd0);

    // add_valid held for three requests of 9
    exp_seq[0] = 12'h009;
    exp_seq[1] = 12'h018;
    exp_seq[2] = 12'h027;
    k = 0;
    add_valid = 1'b1;
    add_value = 4'd9;
    for (int i = 0; i < 30 && k < 3; i++) begin
      tick();
      if (done) begin
        check("held_digits", {20'd0, digits}, {20'd0, exp_seq[k]});
        check("held_ready", {31'd0, add_ready}, 32'd1);
        k++;
      end
    end
    add_valid = 1'b0;
    check("held_count", k, 32'd3);
    tick();
    tick();
    check("held_no_extra", {20'd0, digits}, 32'h027);
    check("held_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
